// File: rtl/ld_st_queue_param_if.sv
// Entry type and handshake interface for ld_st_queue_param.
// Defining LSQ_PERF_CNT_EN adds the stall counter signals to the interface.
package ld_st_queue_pkg;

  localparam int LSQ_PREG_W = 6;
  localparam int LSQ_ROB_W  = 5;

  typedef enum logic {
    op_b_load  = 1'b0,
    op_b_store = 1'b1
  } lsq_op_e;

  typedef struct packed {
    lsq_op_e                opcode;
    logic [LSQ_ROB_W-1:0]   rob_index;
    logic [LSQ_PREG_W-1:0]  pr1_s_ld_st;
    logic [LSQ_PREG_W-1:0]  pr2_s_ld_st;
    logic [LSQ_PREG_W-1:0]  prd_ld_st;
    logic [1:0]             mem_size;
    logic [11:0]            imm;
    logic                   rs1_ready;
    logic                   rs2_ready;
  } ld_st_queue_t;

endpackage

interface ld_st_queue_param_if
  import ld_st_queue_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int NUM_PREGS = 64,
  parameter int ROB_DEPTH = 32
) ();

  logic                         flush;
  logic                         enq_valid;
  logic                         enq_ready;
  ld_st_queue_t                 enq_data;
  logic [NUM_PREGS-1:0]         phys_valid_vector;
  logic [$clog2(ROB_DEPTH)-1:0] rob_head;
  logic                         deq_valid;
  logic                         deq_ready;
  ld_st_queue_t                 deq_data;
  logic [$clog2(NUM_PREGS)-1:0] head_pr1;
  logic [$clog2(NUM_PREGS)-1:0] head_pr2;
  logic [$clog2(DEPTH):0]       count;
  logic                         queue_empty;
  logic                         queue_full;

`ifdef LSQ_PERF_CNT_EN
  logic [31:0]                  stall_store_cnt;
  logic [31:0]                  stall_opnd_cnt;

  modport slave (
    input  flush, enq_valid, enq_data, phys_valid_vector, rob_head, deq_ready,
    output enq_ready, deq_valid, deq_data, head_pr1, head_pr2, count,
           queue_empty, queue_full, stall_store_cnt, stall_opnd_cnt
  );

  modport master (
    output flush, enq_valid, enq_data, phys_valid_vector, rob_head, deq_ready,
    input  enq_ready, deq_valid, deq_data, head_pr1, head_pr2, count,
           queue_empty, queue_full, stall_store_cnt, stall_opnd_cnt
  );
`else
  modport slave (
    input  flush, enq_valid, enq_data, phys_valid_vector, rob_head, deq_ready,
    output enq_ready, deq_valid, deq_data, head_pr1, head_pr2, count,
           queue_empty, queue_full
  );

  modport master (
    output flush, enq_valid, enq_data, phys_valid_vector, rob_head, deq_ready,
    input  enq_ready, deq_valid, deq_data, head_pr1, head_pr2, count,
           queue_empty, queue_full
  );
`endif

endinterface

// File: rtl/ld_st_queue_param.sv
// ld_st_queue_param: in-order load/store issue queue gated on operand readiness and store commit.
// Optional stall performance counters are compiled in when LSQ_PERF_CNT_EN is defined.
module ld_st_queue_param
  import ld_st_queue_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int NUM_PREGS = 64,
  parameter int ROB_DEPTH = 32
) (
  input logic                clk,
  input logic                rst,
  ld_st_queue_param_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PR_W  = $clog2(NUM_PREGS);
  localparam int ROB_W = $clog2(ROB_DEPTH);

  ld_st_queue_t     mem_r  [DEPTH];
  ld_st_queue_t     view_s [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             empty_r;
  logic             full_r;
  logic             deq_valid_r;
  ld_st_queue_t     deq_data_r;

  ld_st_queue_t     head_s;
  logic [PR_W-1:0]  head_pr1_s;
  logic [PR_W-1:0]  head_pr2_s;
  logic [ROB_W-1:0] head_rob_s;
  logic             opnds_rdy_s;
  logic             store_wait_s;
  logic             eligible_s;
  logic             push_s;
  logic             pop_s;

  // Present every stored entry with live operand-ready bits from the register file scoreboard
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      view_s[i]           = mem_r[i];
      view_s[i].rs1_ready = bus.phys_valid_vector[mem_r[i].pr1_s_ld_st];
      view_s[i].rs2_ready = bus.phys_valid_vector[mem_r[i].pr2_s_ld_st];
    end
  end

  // Head eligibility and transfer qualification; only stored entries are considered
  always_comb begin
    head_s       = view_s[rd_ptr_r];
    head_pr1_s   = PR_W'(head_s.pr1_s_ld_st);
    head_pr2_s   = PR_W'(head_s.pr2_s_ld_st);
    head_rob_s   = ROB_W'(head_s.rob_index);
    opnds_rdy_s  = head_s.rs1_ready & head_s.rs2_ready;
    store_wait_s = (head_s.opcode == op_b_store) && (head_rob_s != bus.rob_head);
    eligible_s   = !empty_r && opnds_rdy_s && !store_wait_s;
    push_s       = bus.enq_valid && !full_r && !bus.flush;
    pop_s        = eligible_s && !bus.flush && (!deq_valid_r || bus.deq_ready);
  end

  // Next occupancy
  always_comb begin
    count_next_s = count_r;
    if (bus.flush) begin
      count_next_s = {CNT_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CNT_W'(1);
        2'b01:   count_next_s = count_r - CNT_W'(1);
        default: count_next_s = count_r;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates every use
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.enq_data;
    end
  end

  // Pointers and occupancy flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      empty_r <= (count_next_s == {CNT_W{1'b0}});
      full_r  <= (count_next_s == CNT_W'(DEPTH));
    end
  end

  // Issue register: load on pop, drop when consumed, hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deq_valid_r <= 1'b0;
      deq_data_r  <= ld_st_queue_t'({$bits(ld_st_queue_t){1'b0}});
    end else if (bus.flush) begin
      deq_valid_r <= 1'b0;
    end else if (pop_s) begin
      deq_valid_r <= 1'b1;
      deq_data_r  <= head_s;
    end else if (bus.deq_ready) begin
      deq_valid_r <= 1'b0;
    end
  end

  assign bus.enq_ready   = ~full_r;
  assign bus.deq_valid   = deq_valid_r;
  assign bus.deq_data    = deq_data_r;
  assign bus.head_pr1    = head_pr1_s;
  assign bus.head_pr2    = head_pr2_s;
  assign bus.count       = count_r;
  assign bus.queue_empty = empty_r;
  assign bus.queue_full  = full_r;

`ifdef LSQ_PERF_CNT_EN
  logic [31:0] stall_store_cnt_r;
  logic [31:0] stall_opnd_cnt_r;

  // Saturating stall counters; flush deliberately leaves them untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_store_cnt_r <= 32'd0;
      stall_opnd_cnt_r  <= 32'd0;
    end else begin
      if (!empty_r && opnds_rdy_s && store_wait_s && (stall_store_cnt_r != 32'hFFFF_FFFF)) begin
        stall_store_cnt_r <= stall_store_cnt_r + 32'd1;
      end
      if (!empty_r && !opnds_rdy_s && (stall_opnd_cnt_r != 32'hFFFF_FFFF)) begin
        stall_opnd_cnt_r <= stall_opnd_cnt_r + 32'd1;
      end
    end
  end

  assign bus.stall_store_cnt = stall_store_cnt_r;
  assign bus.stall_opnd_cnt  = stall_opnd_cnt_r;
`endif

endmodule

// File: tb/tb_ld_st_queue_param.sv
// Self-checking bench for ld_st_queue_param (DEPTH=4) against a queue-based reference model.
module tb_ld_st_queue_param;
  import ld_st_queue_pkg::*;

  localparam int DEPTH     = 4;
  localparam int NUM_PREGS = 64;
  localparam int ROB_DEPTH = 32;
  localparam logic [63:0] PVV_BASE = {4'b0000, 60'hFFF_FFFF_FFFF_FFFF};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  ld_st_queue_t m_q[$];
  logic         m_valid;
  ld_st_queue_t m_data;
  int unsigned  m_sst;
  int unsigned  m_sop;

  ld_st_queue_param_if #(.DEPTH(DEPTH), .NUM_PREGS(NUM_PREGS), .ROB_DEPTH(ROB_DEPTH)) bus ();

  ld_st_queue_param #(.DEPTH(DEPTH), .NUM_PREGS(NUM_PREGS), .ROB_DEPTH(ROB_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic ld_st_queue_t mk(lsq_op_e op, logic [4:0] rob, logic [5:0] p1, logic [5:0] p2,
                                      logic [11:0] tag);
    ld_st_queue_t e;
    e             = '0;
    e.opcode      = op;
    e.rob_index   = rob;
    e.pr1_s_ld_st = p1;
    e.pr2_s_ld_st = p2;
    e.prd_ld_st   = p1 ^ p2;
    e.mem_size    = 2'd2;
    e.imm         = tag;
    return e;
  endfunction

  task automatic idle();
    bus.flush             = 1'b0;
    bus.enq_valid         = 1'b0;
    bus.enq_data          = '0;
    bus.deq_ready         = 1'b1;
    bus.rob_head          = 5'd0;
    bus.phys_valid_vector = PVV_BASE;
  endtask

  task automatic model_clear();
    m_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_sst   = 0;
    m_sop   = 0;
  endtask

  // One clock: reference model decides from the inputs and stored contents, then advances.
  task automatic cycle();
    ld_st_queue_t h;
    ld_st_queue_t in_e;
    logic r1, r2, st_wait, elig, pop, push, fl, rdy;
    elig = 1'b0;
    fl   = bus.flush;
    rdy  = bus.deq_ready;
    in_e = bus.enq_data;
    if (m_q.size() > 0) begin
      h       = m_q[0];
      r1      = bus.phys_valid_vector[h.pr1_s_ld_st];
      r2      = bus.phys_valid_vector[h.pr2_s_ld_st];
      st_wait = (h.opcode == op_b_store) && (h.rob_index != bus.rob_head);
      elig    = r1 && r2 && !st_wait;
      if (r1 && r2 && st_wait) m_sst++;
      if (!(r1 && r2)) m_sop++;
    end
    pop  = elig && !fl && (!m_valid || rdy);
    push = bus.enq_valid && (m_q.size() < DEPTH) && !fl;
    @(posedge clk);
    if (fl) begin
      m_q.delete();
      m_valid = 1'b0;
    end else begin
      if (pop) begin
        h           = m_q.pop_front();
        h.rs1_ready = 1'b1;
        h.rs2_ready = 1'b1;
        m_data      = h;
        m_valid     = 1'b1;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      if (push) m_q.push_back(in_e);
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL rst_count got %0d exp 0", bus.count); end
    n_cmp++; if (bus.queue_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %b exp 1", bus.queue_empty); end
    n_cmp++; if (bus.queue_full !== 1'b0) begin n_bad++; $display("FAIL rst_full got %b exp 0", bus.queue_full); end
    n_cmp++; if (bus.enq_ready !== 1'b1) begin n_bad++; $display("FAIL rst_enq_ready got %b exp 1", bus.enq_ready); end
    n_cmp++; if (bus.deq_valid !== 1'b0) begin n_bad++; $display("FAIL rst_deq_valid got %b exp 0", bus.deq_valid); end
    n_cmp++; if (bus.deq_data !== ld_st_queue_t'(0)) begin n_bad++; $display("FAIL rst_deq_data got %h exp 0", bus.deq_data); end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_full();
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.enq_data  = mk(op_b_load, 5'd0, 6'd60, 6'(i + 1), 12'(12'h100 + i));
      bus.enq_valid = 1'b1;
      cycle();
    end
    n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL full_count got %0d exp 4", bus.count); end
    n_cmp++; if (bus.queue_full !== 1'b1) begin n_bad++; $display("FAIL full_flag got %b exp 1", bus.queue_full); end
    n_cmp++; if (bus.enq_ready !== 1'b0) begin n_bad++; $display("FAIL full_enq_ready got %b exp 0", bus.enq_ready); end
    n_cmp++; if (bus.head_pr1 !== 6'd60) begin n_bad++; $display("FAIL full_head_pr1 got %0d exp 60", bus.head_pr1); end
    bus.enq_data = mk(op_b_load, 5'd0, 6'd1, 6'd2, 12'h1FF);
    cycle();
    bus.enq_valid = 1'b0;
    n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL full_drop_count got %0d exp 4", bus.count); end
    n_cmp++; if (bus.deq_valid !== 1'b0) begin n_bad++; $display("FAIL full_no_issue got %b exp 0", bus.deq_valid); end
    bus.phys_valid_vector = {64{1'b1}};
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_cmp++;
      if (bus.deq_valid !== 1'b1 || bus.deq_data.imm !== 12'(12'h100 + k)) begin
        n_bad++; $display("FAIL full_drain_%0d got v=%b tag=%h exp v=1 tag=%h", k, bus.deq_valid, bus.deq_data.imm, 12'h100 + k);
      end
    end
    cycle();
    n_cmp++; if (bus.count !== 3'd0 || bus.deq_valid !== 1'b0) begin n_bad++; $display("FAIL full_after_drain got cnt=%0d v=%b exp cnt=0 v=0", bus.count, bus.deq_valid); end
  endtask

  task automatic test_latency();
    ld_st_queue_t exp_e;
    idle();
    exp_e           = mk(op_b_load, 5'd7, 6'd1, 6'd2, 12'h200);
    bus.enq_data    = exp_e;
    bus.enq_valid   = 1'b1;
    cycle();
    bus.enq_valid   = 1'b0;
    n_cmp++; if (bus.deq_valid !== 1'b0 || bus.count !== 3'd1) begin n_bad++; $display("FAIL lat_cycle1 got v=%b cnt=%0d exp v=0 cnt=1", bus.deq_valid, bus.count); end
    cycle();
    exp_e.rs1_ready = 1'b1;
    exp_e.rs2_ready = 1'b1;
    n_cmp++; if (bus.deq_valid !== 1'b1) begin n_bad++; $display("FAIL lat_cycle2_valid got %b exp 1", bus.deq_valid); end
    n_cmp++; if (bus.deq_data !== exp_e) begin n_bad++; $display("FAIL lat_data got %h exp %h", bus.deq_data, exp_e); end
    n_cmp++; if (bus.count !== 3'd0 || bus.queue_empty !== 1'b1) begin n_bad++; $display("FAIL lat_count got %0d exp 0", bus.count); end
    cycle();
    n_cmp++; if (bus.deq_valid !== 1'b0) begin n_bad++; $display("FAIL lat_release got %b exp 0", bus.deq_valid); end
  endtask

  task automatic test_store();
    int unsigned sst0;
    idle();
    bus.rob_head  = 5'd3;
    bus.enq_data  = mk(op_b_store, 5'd5, 6'd3, 6'd4, 12'h300);
    bus.enq_valid = 1'b1;
    cycle();
    bus.enq_valid = 1'b0;
    sst0 = m_sst;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_cmp++; if (bus.deq_valid !== 1'b0 || bus.count !== 3'd1) begin n_bad++; $display("FAIL st_wait_%0d got v=%b cnt=%0d exp v=0 cnt=1", i, bus.deq_valid, bus.count); end
    end
    bus.rob_head = 5'd5;
    cycle();
    n_cmp++;
    if (bus.deq_valid !== 1'b1 || bus.deq_data.imm !== 12'h300 || bus.deq_data.opcode !== op_b_store) begin
      n_bad++; $display("FAIL st_issue got v=%b tag=%h exp v=1 tag=300", bus.deq_valid, bus.deq_data.imm);
    end
`ifdef LSQ_PERF_CNT_EN
    n_cmp++; if (bus.stall_store_cnt !== sst0 + 32'd10) begin n_bad++; $display("FAIL st_stall_cnt got %0d exp %0d", bus.stall_store_cnt, sst0 + 10); end
`endif
    idle();
    cycle();
  endtask

  task automatic test_backpressure();
    idle();
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.enq_data  = mk(op_b_load, 5'd0, 6'(10 + i), 6'(20 + i), 12'(12'h400 + i));
      bus.enq_valid = 1'b1;
      cycle();
    end
    bus.enq_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cycle();
      n_cmp++;
      if (bus.deq_valid !== 1'b1 || bus.deq_data.imm !== 12'h400 || bus.count !== 3'd2 || bus.head_pr1 !== 6'd11) begin
        n_bad++; $display("FAIL bp_hold_%0d got v=%b tag=%h cnt=%0d pr1=%0d exp v=1 tag=400 cnt=2 pr1=11", i, bus.deq_valid, bus.deq_data.imm, bus.count, bus.head_pr1);
      end
    end
    bus.deq_ready = 1'b1;
    cycle();
    n_cmp++; if (bus.deq_data.imm !== 12'h401 || bus.count !== 3'd1) begin n_bad++; $display("FAIL bp_next got tag=%h cnt=%0d exp tag=401 cnt=1", bus.deq_data.imm, bus.count); end
    cycle();
    n_cmp++; if (bus.deq_data.imm !== 12'h402 || bus.count !== 3'd0) begin n_bad++; $display("FAIL bp_last got tag=%h cnt=%0d exp tag=402 cnt=0", bus.deq_data.imm, bus.count); end
    cycle();
  endtask

  task automatic test_wrap();
    idle();
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.enq_data  = mk(op_b_load, 5'd0, 6'(i + 1), 6'(i + 2), 12'(12'h500 + i));
      bus.enq_valid = 1'b1;
      cycle();
    end
    n_cmp++; if (bus.count !== 3'd2 || bus.deq_data.imm !== 12'h500) begin n_bad++; $display("FAIL wrap_prefill got cnt=%0d tag=%h exp cnt=2 tag=500", bus.count, bus.deq_data.imm); end
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.enq_data = mk(op_b_load, 5'd0, 6'(i % 40), 6'((i + 3) % 40), 12'(12'h503 + i));
      cycle();
      n_cmp++;
      if (bus.count !== 3'd2 || bus.deq_valid !== 1'b1 || bus.deq_data.imm !== 12'(12'h501 + i)) begin
        n_bad++; $display("FAIL wrap_pair_%0d got cnt=%0d v=%b tag=%h exp cnt=2 v=1 tag=%h", i, bus.count, bus.deq_valid, bus.deq_data.imm, 12'h501 + i);
      end
    end
    bus.enq_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (bus.deq_valid !== m_valid || (m_valid && bus.deq_data !== m_data)) begin
        n_bad++; $display("FAIL wrap_drain_%0d got v=%b d=%h exp v=%b d=%h", i, bus.deq_valid, bus.deq_data, m_valid, m_data);
      end
    end
  endtask

  task automatic test_flush();
    int unsigned sst0;
    int unsigned sop0;
    idle();
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.enq_data  = mk(op_b_load, 5'd0, 6'(i + 5), 6'(i + 6), 12'(12'h600 + i));
      bus.enq_valid = 1'b1;
      cycle();
    end
    n_cmp++; if (bus.count !== 3'd3 || bus.deq_valid !== 1'b1) begin n_bad++; $display("FAIL fl_setup got cnt=%0d v=%b exp cnt=3 v=1", bus.count, bus.deq_valid); end
    sst0 = m_sst;
    sop0 = m_sop;
    bus.flush     = 1'b1;
    bus.enq_data  = mk(op_b_load, 5'd0, 6'd1, 6'd1, 12'h6FF);
    bus.deq_ready = 1'b1;
    cycle();
    bus.flush     = 1'b0;
    bus.enq_valid = 1'b0;
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL fl_count got %0d exp 0", bus.count); end
    n_cmp++; if (bus.deq_valid !== 1'b0) begin n_bad++; $display("FAIL fl_deq_valid got %b exp 0", bus.deq_valid); end
    n_cmp++; if (bus.queue_empty !== 1'b1 || bus.enq_ready !== 1'b1) begin n_bad++; $display("FAIL fl_empty got e=%b r=%b exp 1 1", bus.queue_empty, bus.enq_ready); end
`ifdef LSQ_PERF_CNT_EN
    n_cmp++; if (bus.stall_store_cnt !== sst0 || bus.stall_opnd_cnt !== sop0) begin n_bad++; $display("FAIL fl_perf got %0d/%0d exp %0d/%0d", bus.stall_store_cnt, bus.stall_opnd_cnt, sst0, sop0); end
`endif
    cycle();
    n_cmp++; if (bus.count !== 3'd0 || bus.deq_valid !== 1'b0) begin n_bad++; $display("FAIL fl_dropped got cnt=%0d v=%b exp 0 0", bus.count, bus.deq_valid); end
  endtask

  task automatic test_random();
    logic [63:0]  pvv;
    ld_st_queue_t e;
    idle();
    for (int i = 0; i < 400; i++) begin
      pvv       = PVV_BASE;
      pvv[7:0]  = 8'($urandom) | 8'($urandom);
      bus.phys_valid_vector = pvv;
      bus.enq_valid = ($urandom_range(0, 99) < 60);
      bus.deq_ready = ($urandom_range(0, 99) < 70);
      bus.flush     = ($urandom_range(0, 99) < 3);
      bus.rob_head  = 5'($urandom_range(0, 3));
      e = mk(lsq_op_e'(1'($urandom_range(0, 1))), 5'($urandom_range(0, 3)),
             6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 12'(i));
      e.rs1_ready  = 1'($urandom);
      e.rs2_ready  = 1'($urandom);
      bus.enq_data = e;
      cycle();
      n_cmp++;
      if (bus.count !== 3'(m_q.size()) || bus.queue_empty !== (m_q.size() == 0) ||
          bus.queue_full !== (m_q.size() == DEPTH) || bus.enq_ready !== (m_q.size() != DEPTH)) begin
        n_bad++; $display("FAIL rnd_occ cyc %0d got cnt=%0d e=%b f=%b exp cnt=%0d", i, bus.count, bus.queue_empty, bus.queue_full, m_q.size());
      end
      n_cmp++;
      if (bus.deq_valid !== m_valid || (m_valid && bus.deq_data !== m_data)) begin
        n_bad++; $display("FAIL rnd_deq cyc %0d got v=%b d=%h exp v=%b d=%h", i, bus.deq_valid, bus.deq_data, m_valid, m_data);
      end
      if (m_q.size() > 0) begin
        n_cmp++;
        if (bus.head_pr1 !== m_q[0].pr1_s_ld_st || bus.head_pr2 !== m_q[0].pr2_s_ld_st) begin
          n_bad++; $display("FAIL rnd_head cyc %0d got %0d/%0d exp %0d/%0d", i, bus.head_pr1, bus.head_pr2, m_q[0].pr1_s_ld_st, m_q[0].pr2_s_ld_st);
        end
      end
`ifdef LSQ_PERF_CNT_EN
      n_cmp++;
      if (bus.stall_store_cnt !== m_sst || bus.stall_opnd_cnt !== m_sop) begin
        n_bad++; $display("FAIL rnd_perf cyc %0d got %0d/%0d exp %0d/%0d", i, bus.stall_store_cnt, bus.stall_opnd_cnt, m_sst, m_sop);
      end
`endif
    end
    idle();
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
  endtask

  task automatic test_async_reset();
    idle();
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.enq_data  = mk(op_b_load, 5'd0, 6'd1, 6'd2, 12'(12'h700 + i));
      bus.enq_valid = 1'b1;
      cycle();
    end
    bus.enq_valid = 1'b0;
    n_cmp++; if (bus.deq_valid !== 1'b1 || bus.count !== 3'd1) begin n_bad++; $display("FAIL ar_setup got v=%b cnt=%0d exp 1 1", bus.deq_valid, bus.count); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.count !== 3'd0 || bus.deq_valid !== 1'b0 || bus.queue_empty !== 1'b1 || bus.deq_data !== ld_st_queue_t'(0)) begin
      n_bad++; $display("FAIL ar_immediate got cnt=%0d v=%b e=%b exp cnt=0 v=0 e=1", bus.count, bus.deq_valid, bus.queue_empty);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    idle();
    bus.enq_data  = mk(op_b_load, 5'd0, 6'd1, 6'd2, 12'h7A0);
    bus.enq_valid = 1'b1;
    cycle();
    bus.enq_valid = 1'b0;
    n_cmp++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL ar_first_enq got cnt=%0d exp 1", bus.count); end
    cycle();
    n_cmp++; if (bus.deq_valid !== 1'b1 || bus.deq_data.imm !== 12'h7A0) begin n_bad++; $display("FAIL ar_first_issue got v=%b tag=%h exp 1 7a0", bus.deq_valid, bus.deq_data.imm); end
  endtask

  initial begin
    model_clear();
    idle();
    test_reset();
    test_full();
    test_latency();
    test_store();
    test_backpressure();
    test_wrap();
    test_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
